// File: rtl/multi_pattern_sequence_detector.sv
// ---------------------------------------------------------------------------
// multi_pattern_sequence_detector
//
// Watches one serial bit stream and compares the most recent SEQ_W valid bits
// against NUM_PAT independently programmable patterns. Every slot has its own
// don't-care mask, overlap mode, one-cycle seen pulse and saturating counter.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   cfg_we       write strobe for one pattern slot
//   cfg_idx      slot index; values >= NUM_PAT are ignored
//   cfg_pattern  target sequence, MSB is the oldest bit
//   cfg_mask     1 = compare bit, 0 = don't care
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   din_valid    din is sampled only when high
//   din          serial data bit
//   clr_cnt      synchronous clear of all match counters (wins over a match)
//   seen         bit i pulses for one cycle after a match of pattern i
//   match_cnt    counter i at bits [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module multi_pattern_sequence_detector #(
    parameter int SEQ_W   = 5,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [SEQ_W-1:0]         cfg_pattern,
    input  logic [SEQ_W-1:0]         cfg_mask,
    input  logic                     cfg_overlap,
    input  logic                     din_valid,
    input  logic                     din,
    input  logic                     clr_cnt,
    output logic [NUM_PAT-1:0]       seen,
    output logic [NUM_PAT*CNT_W-1:0] match_cnt
);

    localparam int                FILL_W   = $clog2(SEQ_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_W);
    // The bit being accepted on this edge completes the window, so one
    // fewer than SEQ_W previously accepted bits is enough.
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(SEQ_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [SEQ_W-1:0]         sh_q, sh_d;
    logic [SEQ_W-1:0]         pat_q  [NUM_PAT];
    logic [SEQ_W-1:0]         pat_d  [NUM_PAT];
    logic [SEQ_W-1:0]         mask_q [NUM_PAT];
    logic [SEQ_W-1:0]         mask_d [NUM_PAT];
    logic [FILL_W-1:0]        fill_q [NUM_PAT];
    logic [FILL_W-1:0]        fill_d [NUM_PAT];
    logic [NUM_PAT-1:0]       ovl_q, ovl_d;
    logic [NUM_PAT-1:0]       armed_q, armed_d;
    logic [NUM_PAT-1:0]       seen_q, seen_d;
    logic [NUM_PAT*CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_PAT-1:0]       wr_s;
    logic [NUM_PAT-1:0]       hit_s;

    // Next-state logic for the shared shift register and every pattern slot.
    always_comb begin
        sh_d    = sh_q;
        ovl_d   = ovl_q;
        armed_d = armed_q;
        seen_d  = {NUM_PAT{1'b0}};
        cnt_d   = cnt_q;
        wr_s    = {NUM_PAT{1'b0}};
        hit_s   = {NUM_PAT{1'b0}};

        if (din_valid) begin
            sh_d = {sh_q[SEQ_W-2:0], din};
        end else begin
            sh_d = sh_q;
        end

        for (int i = 0; i < NUM_PAT; i++) begin
            pat_d[i]  = pat_q[i];
            mask_d[i] = mask_q[i];
            fill_d[i] = fill_q[i];

            // Indices >= NUM_PAT never equal any slot number, so they drop out.
            wr_s[i]  = cfg_we && (cfg_idx == IDX_W'(i));
            // A write to this slot on the same edge suppresses its match.
            hit_s[i] = din_valid && armed_q[i] && !wr_s[i] &&
                       (fill_q[i] >= FILL_THR) &&
                       (((sh_d ^ pat_q[i]) & mask_q[i]) == {SEQ_W{1'b0}});

            if (wr_s[i]) begin
                pat_d[i]   = cfg_pattern;
                mask_d[i]  = cfg_mask;
                ovl_d[i]   = cfg_overlap;
                armed_d[i] = 1'b1;
                fill_d[i]  = {FILL_W{1'b0}};
            end else if (hit_s[i] && !ovl_q[i]) begin
                fill_d[i]  = {FILL_W{1'b0}};
            end else if (din_valid && (fill_q[i] != FILL_MAX)) begin
                fill_d[i]  = fill_q[i] + FILL_W'(1);
            end else begin
                fill_d[i]  = fill_q[i];
            end

            seen_d[i] = hit_s[i];

            if (clr_cnt) begin
                cnt_d[i*CNT_W +: CNT_W] = {CNT_W{1'b0}};
            end else if (hit_s[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end else begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W];
            end
        end
    end

    // State registers; reset leaves slots disarmed with full masks and overlap on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q    <= {SEQ_W{1'b0}};
            ovl_q   <= {NUM_PAT{1'b1}};
            armed_q <= {NUM_PAT{1'b0}};
            seen_q  <= {NUM_PAT{1'b0}};
            cnt_q   <= {(NUM_PAT*CNT_W){1'b0}};
            for (int i = 0; i < NUM_PAT; i++) begin
                pat_q[i]  <= {SEQ_W{1'b0}};
                mask_q[i] <= {SEQ_W{1'b1}};
                fill_q[i] <= {FILL_W{1'b0}};
            end
        end else begin
            sh_q    <= sh_d;
            ovl_q   <= ovl_d;
            armed_q <= armed_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_PAT; i++) begin
                pat_q[i]  <= pat_d[i];
                mask_q[i] <= mask_d[i];
                fill_q[i] <= fill_d[i];
            end
        end
    end

    assign seen      = seen_q;
    assign match_cnt = cnt_q;

endmodule
